// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forwarding-select encoding,
// shadow-entry layout and the hard-wired zero register.
package pipe_pkg;

   localparam int SHADOW_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_t;

   typedef struct packed {
      logic                 valid;
      logic [SHADOW_AW-1:0] rd;
      logic                 rf_le;
      logic                 load;
   } shadow_t;

   localparam logic [SHADOW_AW-1:0] REG_ZERO = 5'd0;

   function automatic logic writes_reg(input shadow_t e, input logic [SHADOW_AW-1:0] r);
      return e.valid && e.rf_le && (e.rd == r);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source for one ALU operand, chosen from the EX/MEM/WB shadow
// entries with EX > MEM > WB priority.
module fwd_select
   import pipe_pkg::*;
(
   input  logic [SHADOW_AW-1:0] src,
   input  logic                 used,
   input  shadow_t              ex,
   input  shadow_t              mem,
   input  shadow_t              wb,
   output fwd_sel_t             sel
);

   always_comb begin
      sel = FWD_RF;
      if (used && (src != REG_ZERO)) begin
         // A load in EX blocks lower stages too: its data is not ready and
         // the load-use stall re-evaluates this operand next cycle.
         if (writes_reg(ex, src))
            sel = ex.load ? FWD_RF : FWD_EX;
         else if (writes_reg(mem, src))
            sel = FWD_MEM;
         else if (writes_reg(wb, src))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, operand forwarding and taken-branch IF/ID flush sequencing.
// Define HAZ_PERF_CNT_EN to add the stall_cnt/flush_cnt saturating counters.
module pipeline_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic [1:0]        id_sr,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rf_le,
   input  logic              id_load,
   input  logic              ex_branch_taken,
   output logic              pc_le,
   output logic              if_id_le,
   output logic              id_ex_nop,
   output logic              if_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   typedef enum logic {ST_IDLE, ST_FLUSH} flush_state_t;

   localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

   shadow_t      ex_q, mem_q, wb_q;
   flush_state_t fl_state;
   logic [1:0]   fl_cnt;
   logic         br_pend;
   logic         if_flush_q;
   logic         stall;
   logic         br_ex;
   logic         br_go;
   fwd_sel_t     sel_a, sel_b;

   always_comb begin
      stall = ex_q.valid && ex_q.load && ex_q.rf_le && (ex_q.rd != REG_ZERO) &&
              ((id_sr[0] && (id_ra == ex_q.rd)) || (id_sr[1] && (id_rb == ex_q.rd)));
   end

   assign pc_le     = ~stall;
   assign if_id_le  = ~stall;
   assign id_ex_nop = stall;
   assign if_flush  = if_flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (id_ex_nop || !id_valid)
            ex_q <= '0;
         else
            ex_q <= shadow_t'{valid: 1'b1, rd: id_rd, rf_le: id_rf_le, load: id_load};
      end
   end

   fwd_select u_fwd_a (
      .src  (id_ra),
      .used (id_sr[0]),
      .ex   (ex_q),
      .mem  (mem_q),
      .wb   (wb_q),
      .sel  (sel_a)
   );

   fwd_select u_fwd_b (
      .src  (id_rb),
      .used (id_sr[1]),
      .ex   (ex_q),
      .mem  (mem_q),
      .wb   (wb_q),
      .sel  (sel_b)
   );

   assign fwd_a = sel_a;
   assign fwd_b = sel_b;

   // A branch seen during a stall is parked in br_pend and launched on the
   // first non-stall cycle; the flush count keeps running through stalls.
   assign br_ex = ex_branch_taken && ex_q.valid;
   assign br_go = (br_ex || br_pend) && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fl_state   <= ST_IDLE;
         fl_cnt     <= '0;
         br_pend    <= 1'b0;
         if_flush_q <= 1'b0;
      end else begin
         if (stall && br_ex)
            br_pend <= 1'b1;
         else if (br_go)
            br_pend <= 1'b0;
         case (fl_state)
            ST_IDLE: begin
               if (br_go) begin
                  fl_state   <= ST_FLUSH;
                  fl_cnt     <= '0;
                  if_flush_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (br_go) begin
                  fl_cnt <= '0;
               end else if (fl_cnt == FLUSH_LAST) begin
                  fl_state   <= ST_IDLE;
                  if_flush_q <= 1'b0;
               end else begin
                  fl_cnt <= fl_cnt + 2'd1;
               end
            end
            default: begin
               fl_state   <= ST_IDLE;
               if_flush_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
         if (if_flush_q && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
